// File: rtl/hamming_scrub_ctrl_if.sv
// hamming_scrub_ctrl_if: host request/response and RAM port bundle for hamming_scrub_ctrl
// slave: controller side (takes host requests, drives the RAM port)
// master: environment side (issues host requests, models the RAM)
interface hamming_scrub_ctrl_if #(
  parameter int AW = 4
) ();
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [3:0]    host_wdata;
  logic          host_ready;
  logic          host_rvalid;
  logic [3:0]    host_rdata;
  logic          host_rerr;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [6:0]    mem_wdata;
  logic [6:0]    mem_rdata;
  modport slave (
    input  host_req, host_we, host_addr, host_wdata, mem_rdata,
    output host_ready, host_rvalid, host_rdata, host_rerr, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output host_req, host_we, host_addr, host_wdata, mem_rdata,
    input  host_ready, host_rvalid, host_rdata, host_rerr, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/hamming_scrub_ctrl.sv
// hamming_scrub_ctrl: Hamming(7,4) RAM controller with host port and background scrubber
// clk, rst_n: clock and asynchronous active-low reset
// bus: host request/read response and single-port codeword RAM (slave modport)
// scrub_en: enable periodic scrubbing; err_clr: clear err_count
// err_count, last_syndrome, last_err_addr: error statistics
// Codeword layout is bit[i] = Hamming position i+1: {d3,d2,d1,p4,d0,p2,p1}.
module hamming_encoder (
  input  logic [3:0] data,
  output logic [6:0] code
);
  assign code = {data[3], data[2], data[1], data[1] ^ data[2] ^ data[3],
                 data[0], data[0] ^ data[2] ^ data[3], data[0] ^ data[1] ^ data[3]};
endmodule

module hamming_decoder (
  input  logic [6:0] code,
  output logic [3:0] data,
  output logic [2:0] syndrome
);
  assign syndrome = {code[3] ^ code[4] ^ code[5] ^ code[6],
                     code[1] ^ code[2] ^ code[5] ^ code[6],
                     code[0] ^ code[2] ^ code[4] ^ code[6]};
  // syndrome names the flipped position; only data positions need fixing
  assign data = {code[6] ^ (syndrome == 3'd7), code[5] ^ (syndrome == 3'd6),
                 code[4] ^ (syndrome == 3'd5), code[2] ^ (syndrome == 3'd3)};
endmodule

module hamming_scrub_ctrl #(
  parameter int AW             = 4,
  parameter int DEPTH          = 16,
  parameter int SCRUB_INTERVAL = 256,
  parameter int CW             = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hamming_scrub_ctrl_if.slave  bus,
  input  logic                 scrub_en,
  input  logic                 err_clr,
  output logic [CW-1:0]        err_count,
  output logic [2:0]           last_syndrome,
  output logic [AW-1:0]        last_err_addr
);
  localparam int TW = $clog2(SCRUB_INTERVAL);
  typedef enum logic [1:0] {IDLE, H_RD, S_RD, S_WB} state_t;
  state_t        state, state_nx;
  logic [AW-1:0] scrub_addr, rd_addr;
  logic [TW-1:0] timer;
  logic          scrub_pending;
  logic [3:0]    wb_data, enc_in, dec_data;
  logic [2:0]    syn;
  logic [6:0]    enc_code;
  logic          accept, issue, tc, err_ev, advance;
  hamming_encoder u_enc (.data(enc_in), .code(enc_code));
  hamming_decoder u_dec (.code(bus.mem_rdata), .data(dec_data), .syndrome(syn));
  always_comb begin
    accept         = state == IDLE && bus.host_req;
    issue          = state == IDLE && !bus.host_req && scrub_pending;
    tc             = timer == TW'(SCRUB_INTERVAL - 1);
    err_ev         = (state == H_RD || state == S_RD) && syn != 3'd0;
    advance        = (state == S_RD && syn == 3'd0) || state == S_WB;
    state_nx       = accept ? (bus.host_we ? IDLE : H_RD) : issue ? S_RD :
                     (state == S_RD && syn != 3'd0) ? S_WB : IDLE;
    enc_in         = state == S_WB ? wb_data : bus.host_wdata;
    bus.host_ready = state == IDLE;
    // gated by rst_n so the RAM strobe drops the instant reset asserts
    bus.mem_en     = rst_n && (accept || issue || state == S_WB);
    bus.mem_we     = rst_n && ((accept && bus.host_we) || state == S_WB);
    bus.mem_addr   = accept ? bus.host_addr : scrub_addr;
    bus.mem_wdata  = enc_code;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      scrub_addr      <= '0;
      rd_addr         <= '0;
      timer           <= '0;
      scrub_pending   <= 1'b0;
      wb_data         <= '0;
      bus.host_rvalid <= 1'b0;
      bus.host_rdata  <= '0;
      bus.host_rerr   <= 1'b0;
      err_count       <= '0;
      last_syndrome   <= '0;
      last_err_addr   <= '0;
    end else begin
      state           <= state_nx;
      timer           <= (!scrub_en || tc) ? '0 : timer + 1'b1;
      // a new terminal count re-arms even on the cycle the previous request issues
      scrub_pending   <= scrub_en && (tc || (scrub_pending && !issue));
      bus.host_rvalid <= state == H_RD;
      if (accept) rd_addr <= bus.host_addr;
      if (state == S_RD) wb_data <= dec_data;
      if (advance) scrub_addr <= scrub_addr == AW'(DEPTH - 1) ? '0 : scrub_addr + 1'b1;
      if (state == H_RD) begin
        bus.host_rdata <= dec_data;
        bus.host_rerr  <= syn != 3'd0;
      end
      if (err_clr) err_count <= '0;
      else if (err_ev && err_count != '1) err_count <= err_count + 1'b1;
      if (err_ev) begin
        last_syndrome <= syn;
        last_err_addr <= state == H_RD ? rd_addr : scrub_addr;
      end
    end
  end
endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// tb_hamming_scrub_ctrl: scoreboard bench for hamming_scrub_ctrl with a RAM model
module tb_hamming_scrub_ctrl;
  localparam int AW = 4, DEPTH = 16, SI = 4, CW = 2;
  logic clk = 0, rst_n = 1, scrub_en = 0, err_clr = 0;
  logic [CW-1:0] err_count;
  logic [2:0] last_syndrome;
  logic [AW-1:0] last_err_addr;
  hamming_scrub_ctrl_if #(.AW(AW)) bus ();
  hamming_scrub_ctrl #(.AW(AW), .DEPTH(DEPTH), .SCRUB_INTERVAL(SI), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .scrub_en(scrub_en), .err_clr(err_clr),
    .err_count(err_count), .last_syndrome(last_syndrome), .last_err_addr(last_err_addr));
  always #5 clk = ~clk;

  typedef struct packed {logic [3:0] d; logic e; logic [31:0] at;} exp_t;
  exp_t rq[$];
  exp_t got;
  int vectors = 0, miscompares = 0, cyc = 0, sexp = 0, scrub_reads = 0;
  logic [6:0] mem [DEPTH];
  logic [3:0] data_of [DEPTH];
  logic wb_pending = 0;
  logic [AW-1:0] wb_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // parity bits chosen so every syndrome group XORs to zero
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] c;
    logic p;
    c = {d[3], d[2], d[1], 1'b0, d[0], 2'b00};
    for (int k = 0; k < 3; k++) begin
      p = 0;
      for (int pos = 1; pos <= 7; pos++) if (pos[k]) p ^= c[pos-1];
      c[(1 << k) - 1] = p;
    end
    return c;
  endfunction

  // RAM model plus scrub-order and writeback scoreboard
  always @(posedge clk) begin
    cyc++;
    if (bus.mem_en && !bus.mem_we) begin
      bus.mem_rdata <= mem[bus.mem_addr];
      if (!bus.host_req) begin
        chk("scrub_order", bus.mem_addr, sexp);
        chk("wb_done_before_next_scrub", wb_pending, 0);
        wb_pending = mem[bus.mem_addr] !== enc(data_of[bus.mem_addr]);
        wb_addr = bus.mem_addr;
        sexp = (sexp + 1) % DEPTH;
        scrub_reads++;
      end
    end
    if (bus.mem_en && bus.mem_we) begin
      if (!bus.host_ready) begin
        chk("wb_expected", wb_pending, 1);
        chk("wb_addr", bus.mem_addr, wb_addr);
        chk("wb_data", bus.mem_wdata, enc(data_of[bus.mem_addr]));
        wb_pending = 0;
      end
      mem[bus.mem_addr] = bus.mem_wdata;
    end
  end

  always @(negedge clk) if (bus.host_rvalid) begin
    if (rq.size() == 0) chk("rvalid_spurious", rq.size(), 1);
    else begin
      got = rq.pop_front();
      chk("rdata", bus.host_rdata, got.d);
      chk("rerr", bus.host_rerr, got.e);
      chk("rlatency", cyc, got.at);
    end
  end

  task automatic wait_ready();
    int n = 0;
    #1;
    while (!bus.host_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("ready_timeout", bus.host_ready, 1);
  endtask

  task automatic host_write(input int a, input logic [3:0] d);
    @(negedge clk);
    bus.host_req = 1; bus.host_we = 1; bus.host_addr = AW'(a); bus.host_wdata = d;
    wait_ready();
    data_of[a] = d;
    chk("w_en", bus.mem_en, 1);
    chk("w_we", bus.mem_we, 1);
    chk("w_addr", bus.mem_addr, a);
    chk("w_data", bus.mem_wdata, enc(d));
    @(posedge clk);
    #1 bus.host_req = 0;
  endtask

  task automatic host_read(input int a, input logic [3:0] d, input logic e);
    @(negedge clk);
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = AW'(a);
    wait_ready();
    chk("r_en", bus.mem_en, 1);
    chk("r_we", bus.mem_we, 0);
    chk("r_addr", bus.mem_addr, a);
    rq.push_back('{d: d, e: e, at: cyc + 2});
    @(posedge clk);
    #1 bus.host_req = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sa, wa, base, n;
    logic [6:0] saved;
    bus.host_req = 1; bus.host_we = 1; bus.host_addr = 3; bus.host_wdata = 4'hF;
    bus.mem_rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; data_of[i] = '0; end
    #2 rst_n = 0;
    #1 chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    idle(2);
    bus.host_req = 0;
    rst_n = 1;
    #1;
    chk("rst_ready", bus.host_ready, 1);
    chk("rst_rvalid", bus.host_rvalid, 0);
    chk("rst_rdata", bus.host_rdata, 0);
    chk("rst_rerr", bus.host_rerr, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_last_syn", last_syndrome, 0);
    chk("rst_last_addr", last_err_addr, 0);
    // fill RAM back-to-back, then write/read 4'hA at 3
    for (int i = 0; i < DEPTH; i++) host_write(i, 4'(15 - i));
    host_write(3, 4'hA);
    chk("mem3_codeword", mem[3], 7'h52);
    host_read(3, 4'hA, 0);
    idle(3);
    chk("err_count_clean", err_count, 0);
    // single-bit error at 5 found and repaired by the scrubber
    mem[5] = mem[5] ^ 7'h04;
    scrub_en = 1;
    idle(80);
    chk("scrub_pass", scrub_reads >= 17, 1);
    scrub_en = 0;
    idle(3);
    chk("scrub_err_count", err_count, 1);
    chk("scrub_last_addr", last_err_addr, 5);
    chk("scrub_last_syn", last_syndrome, 3);
    chk("mem5_repaired", mem[5], enc(data_of[5]));
    host_read(5, data_of[5], 0);
    idle(3);
    // host priority over pending scrub, error round then clean round
    for (int round = 0; round < 2; round++) begin
      scrub_en = 1;
      base = scrub_reads;
      wa = (sexp + 8) % DEPTH;
      for (int i = 0; i < 12; i++) host_write(wa, data_of[wa]);
      chk("starved", scrub_reads - base, 0);
      sa = sexp;
      if (round == 0) mem[sa] = mem[sa] ^ 7'h01;
      @(negedge clk);
      #1;
      chk("issue_en", bus.mem_en, 1);
      chk("issue_we", bus.mem_we, 0);
      chk("issue_addr", bus.mem_addr, sa);
      idle(1);
      chk("busy_srd", bus.host_ready, 0);
      idle(1);
      chk("after_srd", bus.host_ready, round == 0 ? 0 : 1);
      if (round == 0) begin
        idle(1);
        chk("after_swb", bus.host_ready, 1);
        chk("round_err_count", err_count, 2);
        chk("round_last_syn", last_syndrome, 1);
        chk("round_last_addr", last_err_addr, sa);
      end
      scrub_en = 0;
      idle(4);
    end
    chk("clean_err_count", err_count, 2);
    // saturation at 3 with CW=2, then err_clr beats a coincident error
    @(negedge clk) err_clr = 1;
    @(negedge clk) err_clr = 0;
    #1 chk("err_clr", err_count, 0);
    mem[0] = mem[0] ^ 7'h40;
    for (int i = 0; i < 3; i++) host_read(0, data_of[0], 1);
    idle(3);
    chk("count3", err_count, 3);
    for (int i = 0; i < 2; i++) host_read(0, data_of[0], 1);
    idle(3);
    chk("saturated", err_count, 3);
    chk("sat_last_syn", last_syndrome, 7);
    chk("sat_last_addr", last_err_addr, 0);
    host_read(0, data_of[0], 1);
    err_clr = 1;
    @(posedge clk);
    #1 err_clr = 0;
    chk("clr_beats_inc", err_count, 0);
    chk("clr_keeps_syn", last_syndrome, 7);
    idle(3);
    // reset during S_WB aborts the writeback
    sa = sexp;
    mem[sa] = mem[sa] ^ 7'h10;
    scrub_en = 1;
    n = 0;
    @(negedge clk);
    #1;
    while (!(bus.mem_en && bus.mem_we && !bus.host_ready) && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("swb_reached", bus.mem_en && bus.mem_we && !bus.host_ready, 1);
    wa = bus.mem_addr;
    saved = mem[wa];
    rst_n = 0;
    #1;
    chk("arst_mem_en", bus.mem_en, 0);
    chk("arst_mem_we", bus.mem_we, 0);
    chk("arst_ready", bus.host_ready, 1);
    chk("arst_rvalid", bus.host_rvalid, 0);
    chk("arst_rdata", bus.host_rdata, 0);
    chk("arst_rerr", bus.host_rerr, 0);
    chk("arst_err_count", err_count, 0);
    chk("arst_last_syn", last_syndrome, 0);
    chk("arst_last_addr", last_err_addr, 0);
    wb_pending = 0;
    sexp = 0;
    scrub_en = 0;
    @(posedge clk);
    #1 chk("arst_no_write", mem[wa], saved);
    @(negedge clk) rst_n = 1;
    base = scrub_reads;
    scrub_en = 1;
    n = 0;
    while (scrub_reads == base && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("scrub_after_reset", scrub_reads > base, 1);
    scrub_en = 0;
    idle(5);
    chk("no_wb_outstanding", wb_pending, 0);
    chk("rq_drained", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hamming_scrub_ctrl.md
Name: hamming_scrub_ctrl

Overview:
- Controller that sits between a host port and an external single-port codeword RAM of 7-bit Hamming(7,4) words.
- It sequences the team's hamming_encoder and hamming_decoder, one instance of each inside the block, for host writes and reads.
- It shares the RAM port with a background scrubber. The scrubber periodically reads each address, corrects single-bit errors and writes the corrected codeword back.
- It reports an error count and the most recent error location.

Parameters:
AW, 4, RAM address width
DEPTH, 16, number of RAM words; scrub address wraps at DEPTH-1; DEPTH <= 2**AW
SCRUB_INTERVAL, 256, clk cycles between scrub requests while scrub_en=1; must be >= 2
CW, 8, error counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
host_req  in  1  host request valid
host_we  in  1  1=write, 0=read; sampled with host_req
host_addr  in  AW  host address
host_wdata  in  4  host write data
host_ready  out  1  request accepted when host_req && host_ready
host_rvalid  out  1  one-cycle pulse, read data valid
host_rdata  out  4  corrected read data
host_rerr  out  1  read had nonzero syndrome
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write enable
mem_addr  out  AW  RAM address
mem_wdata  out  7  codeword to RAM
mem_rdata  in  7  RAM read data, valid one cycle after a read strobe
scrub_en  in  1  enable background scrubbing
err_clr  in  1  synchronous clear of err_count
err_count  out  CW  saturating count of detected errors
last_syndrome  out  3  syndrome of the most recent error
last_err_addr  out  AW  address of the most recent error

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE. scrub_addr, the timer and scrub_pending go to 0.
  - host_rvalid=0, host_rdata=0, host_rerr=0, err_count=0, last_syndrome=0, last_err_addr=0.
  - mem_en=0 and mem_we=0 immediately, with no clock edge required.
  - A reset during any state aborts the access. No writeback is completed.
- FSM states: IDLE, H_RD, S_RD, S_WB.
  - host_ready=1 only in IDLE.
  - mem_en, mem_we, mem_addr and mem_wdata are combinational from state and the accepted request.
- IDLE, host write accepted:
  - Same cycle: mem_en=1, mem_we=1, mem_addr=host_addr, mem_wdata=encode(host_wdata).
  - Stay in IDLE. Back-to-back writes run at one per cycle.
- IDLE, host read accepted:
  - Same cycle: mem_en=1, mem_we=0.
  - Next state H_RD.
- H_RD: decode mem_rdata and register the results.
  - host_rdata=corrected data, host_rerr=(syndrome!=0), host_rvalid=1 on the following cycle.
  - Next state IDLE. Read latency from acceptance to host_rvalid is 2 cycles; reads issue at most every 2 cycles.
  - A host read error updates err_count and the last_* outputs. There is no writeback.
- Scrub timer:
  - While scrub_en=1, the timer counts 0..SCRUB_INTERVAL-1 and wraps.
  - At the terminal count, scrub_pending is set. A terminal count while scrub_pending is already set does not accumulate.
  - When scrub_en=0, the timer and scrub_pending clear. A scrub already in S_RD or S_WB completes.
- Arbitration in IDLE: host_req has strict priority over scrub_pending. A pending scrub waits until a cycle with host_req=0.
- Scrub issue: in IDLE with host_req=0 and scrub_pending=1:
  - mem_en=1, mem_we=0, mem_addr=scrub_addr.
  - scrub_pending clears. Next state S_RD.
- S_RD: decode mem_rdata.
  - Syndrome 0: scrub_addr advances. Next state IDLE.
  - Syndrome nonzero: record the error and latch the corrected data. Next state S_WB.
- S_WB:
  - mem_en=1, mem_we=1, mem_addr=scrub_addr, mem_wdata=encode(corrected data).
  - scrub_addr advances. Next state IDLE.
- scrub_addr advance: increments and wraps from DEPTH-1 to 0.
- Error record:
  - err_count increments by 1 and saturates at 2**CW-1.
  - last_syndrome=syndrome and last_err_addr=address, both registered.
- err_clr: zeroes err_count and takes priority over a same-cycle increment. The last_* outputs are unaffected.
- Host inputs are ignored when host_ready=0. The host must hold host_req until accepted.

Test Plan:
- Reset, then write 4'hA to address 3 -> same cycle mem_we=1, mem_addr=3, mem_wdata=hamming_encoder(4'hA). Read address 3 -> host_rvalid 2 cycles after acceptance, host_rdata=4'hA, host_rerr=0, err_count=0.
- Memory model flips bit 2 of address 5, SCRUB_INTERVAL=4, scrub_en=1 -> scrub reaches address 5 and S_WB writes the original codeword to address 5. err_count=1, last_err_addr=5, last_syndrome nonzero. The next read of address 5 gives host_rerr=0.
- Hold host_req=1 with continuous writes while scrub_pending=1 -> no scrub access occurs. Drop host_req for one cycle -> scrub read issues in that cycle and host_ready=0 for 1 cycle (clean) or 2 cycles (error).
- Let the scrubber run with DEPTH=16 and no errors -> addresses 0..15 are read in order, then 0 again. err_count stays 0.
- CW=2, inject 5 errors -> err_count saturates at 3. err_clr coincident with a sixth error -> err_count=0.
- Assert rst_n=0 while in S_WB -> mem_en=0 with no clock edge, outputs at reset values, scrub_addr=0, no write to RAM.
